// File: rtl/l2_stream_fill.sv
// Line-fill engine for the L2 stream buffer. It issues tagged OpenCAPI reads, reorders the responses by tag and retires lines in request order.
// Optional macro L2_FILL_RSP_ERR_EN adds the i_rsp_err/o_err error path.
module l2_stream_fill #(
  parameter int l2_ncl       = 256,
  parameter int l2_ncl_width = $clog2(l2_ncl),
  parameter int ntag         = 8,
  parameter int tag_width    = $clog2(ntag),
  parameter int data_width   = 512,
  parameter int addr_width   = 64,
  parameter int line_bytes   = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [addr_width-1:0]   i_base,
  input  logic                    i_req_v,
  output logic                    i_req_r,
  output logic                    o_cmd_v,
  input  logic                    o_cmd_r,
  output logic [tag_width-1:0]    o_cmd_tag,
  output logic [addr_width-1:0]   o_cmd_addr,
  input  logic                    i_rsp_v,
  output logic                    i_rsp_r,
  input  logic [tag_width-1:0]    i_rsp_tag,
  input  logic [data_width-1:0]   i_rsp_data,
  output logic                    o_wr_v,
  input  logic                    o_wr_r,
  output logic [l2_ncl_width-1:0] o_wr_ptr,
  output logic [data_width-1:0]   o_wr_data,
  output logic                    o_rsp_v,
  input  logic                    o_rsp_r,
  input  logic                    i_rst_v,
  output logic                    i_rst_r,
`ifdef L2_FILL_RSP_ERR_EN
  input  logic                    i_rsp_err,
  output logic                    o_err,
`endif
  output logic                    o_idle
);

  localparam int cnt_w = $clog2(ntag + 1);

  logic [tag_width-1:0]    alloc_tag, head_tag;
  logic [l2_ncl_width-1:0] alloc_clid, wr_clid;
  logic [cnt_w-1:0]        outstanding, ncomp;
  logic [ntag-1:0]         vld, vld_nxt;
  logic [data_width-1:0]   line_buf [ntag];
  logic [data_width-1:0]   cap_data;

  logic full, issue, cap, retire, notify, frst;

  function automatic logic [l2_ncl_width-1:0] next_clid(input logic [l2_ncl_width-1:0] c);
    if (c == l2_ncl_width'(l2_ncl - 1)) return '0;
    return c + l2_ncl_width'(1);
  endfunction

  // full uses the registered count, so a retire never frees a slot in its own cycle
  assign full    = (outstanding == cnt_w'(ntag));
  assign o_idle  = (outstanding == '0) && (ncomp == '0);
  assign i_rst_r = i_rst_v & o_idle;
  assign frst    = i_rst_v & i_rst_r;

  assign o_cmd_v    = i_req_v & ~full & ~i_rst_v;
  assign i_req_r    = o_cmd_r & ~full & ~i_rst_v;
  assign issue      = i_req_v & i_req_r;
  assign o_cmd_tag  = alloc_tag;
  assign o_cmd_addr = i_base + addr_width'(alloc_clid) * addr_width'(line_bytes);

  assign i_rsp_r = 1'b1;
  assign cap     = i_rsp_v & ~vld[i_rsp_tag];

`ifdef L2_FILL_RSP_ERR_EN
  assign cap_data = i_rsp_err ? '0 : i_rsp_data;
`else
  assign cap_data = i_rsp_data;
`endif

  assign o_wr_v    = vld[head_tag];
  assign o_wr_data = line_buf[head_tag];
  assign o_wr_ptr  = wr_clid;
  assign retire    = o_wr_v & o_wr_r;

  assign o_rsp_v = (ncomp != '0);
  assign notify  = o_rsp_v & o_rsp_r;

  always_comb begin
    vld_nxt = vld;
    if (cap)    vld_nxt[i_rsp_tag] = 1'b1;
    if (retire) vld_nxt[head_tag]  = 1'b0;
    if (frst)   vld_nxt            = '0;
  end

  // Line storage is data only and carries no reset
  always_ff @(posedge clk) begin
    if (cap) line_buf[i_rsp_tag] <= cap_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alloc_tag   <= '0;
      head_tag    <= '0;
      alloc_clid  <= '0;
      wr_clid     <= '0;
      outstanding <= '0;
      ncomp       <= '0;
      vld         <= '0;
    end else begin
      vld <= vld_nxt;

      if (frst) begin
        alloc_tag  <= '0;
        alloc_clid <= '0;
      end else if (issue) begin
        alloc_tag  <= alloc_tag + tag_width'(1);
        alloc_clid <= next_clid(alloc_clid);
      end

      if (frst) begin
        head_tag <= '0;
        wr_clid  <= '0;
      end else if (retire) begin
        head_tag <= head_tag + tag_width'(1);
        wr_clid  <= next_clid(wr_clid);
      end

      case ({issue, retire})
        2'b10:   outstanding <= outstanding + cnt_w'(1);
        2'b01:   outstanding <= outstanding - cnt_w'(1);
        default: outstanding <= outstanding;
      endcase

      case ({retire, notify})
        2'b10:   ncomp <= ncomp + cnt_w'(1);
        2'b01:   ncomp <= ncomp - cnt_w'(1);
        default: ncomp <= ncomp;
      endcase
    end
  end

`ifdef L2_FILL_RSP_ERR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      o_err <= 1'b0;
    else if (frst)                   o_err <= 1'b0;
    else if (i_rsp_v && i_rsp_err)   o_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_l2_stream_fill.sv
// Directed bench for l2_stream_fill: a vector table for single-line and reorder traffic,
// plus hand sequences for full, backpressure, pointer wrap and functional reset.
module tb_l2_stream_fill;

  localparam logic [63:0] BASE = 64'h1000;

  logic         clk;
  logic         reset;
  logic [63:0]  i_base;
  logic         i_req_v, i_req_r;
  logic         o_cmd_v, o_cmd_r;
  logic [2:0]   o_cmd_tag;
  logic [63:0]  o_cmd_addr;
  logic         i_rsp_v, i_rsp_r;
  logic [2:0]   i_rsp_tag;
  logic [511:0] i_rsp_data;
  logic         o_wr_v, o_wr_r;
  logic [7:0]   o_wr_ptr;
  logic [511:0] o_wr_data;
  logic         o_rsp_v, o_rsp_r;
  logic         i_rst_v, i_rst_r;
  logic         o_idle;

  int n_pass  = 0;
  int n_total = 0;

  l2_stream_fill dut (
    .clk(clk), .reset(reset), .i_base(i_base),
    .i_req_v(i_req_v), .i_req_r(i_req_r),
    .o_cmd_v(o_cmd_v), .o_cmd_r(o_cmd_r), .o_cmd_tag(o_cmd_tag), .o_cmd_addr(o_cmd_addr),
    .i_rsp_v(i_rsp_v), .i_rsp_r(i_rsp_r), .i_rsp_tag(i_rsp_tag), .i_rsp_data(i_rsp_data),
    .o_wr_v(o_wr_v), .o_wr_r(o_wr_r), .o_wr_ptr(o_wr_ptr), .o_wr_data(o_wr_data),
    .o_rsp_v(o_rsp_v), .o_rsp_r(o_rsp_r),
    .i_rst_v(i_rst_v), .i_rst_r(i_rst_r), .o_idle(o_idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit req_v, cmd_r, rsp_v;
    int rsp_tag, rsp_key;
    bit wr_r, rsp_r;
    bit e_cmd_v, e_req_r;
    int e_tag, e_off;
    bit e_wr_v;
    int e_ptr, e_key;
    bit e_rspv, e_idle;
  } vec_t;

  vec_t vt [19];

  function automatic logic [511:0] dat(input int k);
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = 32'h5A000000 + 32'(k * 16 + i);
    return r;
  endfunction

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    i_req_v = 0; o_cmd_r = 0; i_rsp_v = 0; i_rsp_tag = '0; i_rsp_data = '0;
    o_wr_r = 0; o_rsp_r = 0; i_rst_v = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int issued, written, cnt, pend_line, nxt_line;
    bit pend, nxt_pend;

    vt[0]  = '{1,1,0,0,0,1,1, 1,1,0,'h000, 0,0,0,   0,1};
    vt[1]  = '{0,0,1,0,0,1,1, 0,0,0,0,     0,0,0,   0,0};
    vt[2]  = '{0,0,0,0,0,1,1, 0,0,0,0,     1,0,0,   0,0};
    vt[3]  = '{0,0,0,0,0,1,1, 0,0,0,0,     0,0,0,   1,0};
    vt[4]  = '{0,0,0,0,0,1,1, 0,0,0,0,     0,0,0,   0,1};
    vt[5]  = '{1,1,0,0,0,1,1, 1,1,1,'h080, 0,0,0,   0,1};
    vt[6]  = '{1,1,0,0,0,1,1, 1,1,2,'h100, 0,0,0,   0,0};
    vt[7]  = '{1,1,0,0,0,1,1, 1,1,3,'h180, 0,0,0,   0,0};
    vt[8]  = '{1,1,0,0,0,1,1, 1,1,4,'h200, 0,0,0,   0,0};
    vt[9]  = '{0,0,1,4,4,1,1, 0,0,0,0,     0,0,0,   0,0};
    vt[10] = '{0,0,1,2,2,1,1, 0,0,0,0,     0,0,0,   0,0};
    vt[11] = '{0,0,1,3,3,1,1, 0,0,0,0,     0,0,0,   0,0};
    vt[12] = '{0,0,1,1,1,1,1, 0,0,0,0,     0,0,0,   0,0};
    vt[13] = '{0,0,1,4,99,1,1,0,0,0,0,     1,1,1,   0,0};
    vt[14] = '{0,0,0,0,0,1,1, 0,0,0,0,     1,2,2,   1,0};
    vt[15] = '{0,0,0,0,0,1,1, 0,0,0,0,     1,3,3,   1,0};
    vt[16] = '{0,0,0,0,0,1,1, 0,0,0,0,     1,4,4,   1,0};
    vt[17] = '{0,0,0,0,0,1,1, 0,0,0,0,     0,0,0,   1,0};
    vt[18] = '{0,0,0,0,0,1,1, 0,0,0,0,     0,0,0,   0,1};

    i_base = BASE;
    reset  = 1'b0;
    clear_inputs();
    #2;
    chk("rst.cmd_v", o_cmd_v, 0);
    chk("rst.wr_v",  o_wr_v, 0);
    chk("rst.rsp_v", o_rsp_v, 0);
    chk("rst.rst_r", i_rst_r, 0);
    chk("rst.idle",  o_idle, 1);
    chk("rst.rsp_r", i_rsp_r, 1);
    do_reset();

    // vector table: single line, then reorder with a dropped duplicate
    for (int r = 0; r < 19; r++) begin
      i_req_v = vt[r].req_v; o_cmd_r = vt[r].cmd_r;
      i_rsp_v = vt[r].rsp_v; i_rsp_tag = 3'(vt[r].rsp_tag); i_rsp_data = dat(vt[r].rsp_key);
      o_wr_r = vt[r].wr_r; o_rsp_r = vt[r].rsp_r;
      @(negedge clk);
      chk($sformatf("v%0d.cmd_v", r), o_cmd_v, vt[r].e_cmd_v);
      chk($sformatf("v%0d.req_r", r), i_req_r, vt[r].e_req_r);
      chk($sformatf("v%0d.wr_v", r),  o_wr_v,  vt[r].e_wr_v);
      chk($sformatf("v%0d.rsp_v", r), o_rsp_v, vt[r].e_rspv);
      chk($sformatf("v%0d.idle", r),  o_idle,  vt[r].e_idle);
      if (vt[r].e_cmd_v) begin
        chk($sformatf("v%0d.tag", r),  o_cmd_tag, vt[r].e_tag);
        chk($sformatf("v%0d.addr", r), o_cmd_addr, BASE + 64'(vt[r].e_off));
      end
      if (vt[r].e_wr_v) begin
        chk($sformatf("v%0d.ptr", r),  o_wr_ptr, vt[r].e_ptr);
        chk($sformatf("v%0d.data", r), o_wr_data, dat(vt[r].e_key));
      end
      adv();
    end

    // full: eight commands, ninth blocked until a retire has registered
    do_reset();
    i_req_v = 1; o_cmd_r = 1; o_wr_r = 1; o_rsp_r = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("full.req_r", i_req_r, 1);
      chk("full.tag", o_cmd_tag, k);
      chk("full.addr", o_cmd_addr, BASE + 64'(k * 128));
      adv();
    end
    @(negedge clk);
    chk("full.blk_req_r", i_req_r, 0);
    chk("full.blk_cmd_v", o_cmd_v, 0);
    adv();
    i_rsp_v = 1; i_rsp_tag = 0; i_rsp_data = dat(50);
    @(negedge clk);
    chk("full.blk2_req_r", i_req_r, 0);
    chk("full.pre_wr_v", o_wr_v, 0);
    adv();
    i_rsp_v = 0;
    @(negedge clk);
    chk("full.wr_v", o_wr_v, 1);
    chk("full.wr_data", o_wr_data, dat(50));
    chk("full.same_cycle_req_r", i_req_r, 0);
    adv();
    @(negedge clk);
    chk("full.reopen_req_r", i_req_r, 1);
    chk("full.reopen_tag", o_cmd_tag, 0);
    chk("full.reopen_addr", o_cmd_addr, BASE + 64'h400);
    adv();
    i_req_v = 0;

    // backpressure: four ready lines held, then drained
    do_reset();
    o_cmd_r = 1; i_req_v = 1;
    repeat (4) adv();
    i_req_v = 0;
    for (int k = 0; k < 4; k++) begin
      i_rsp_v = 1; i_rsp_tag = 3'(k); i_rsp_data = dat(200 + k);
      adv();
    end
    i_rsp_v = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp.hold_wr_v", o_wr_v, 1);
      chk("bp.hold_ptr", o_wr_ptr, 0);
      chk("bp.hold_rsp_v", o_rsp_v, 0);
      adv();
    end
    o_wr_r = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp.drain_wr_v", o_wr_v, 1);
      chk("bp.drain_ptr", o_wr_ptr, k);
      chk("bp.drain_data", o_wr_data, dat(200 + k));
      adv();
    end
    o_rsp_r = 1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) chk("bp.after_wr_v", o_wr_v, 0);
      if (o_rsp_v) cnt++;
      adv();
    end
    chk("bp.notify_beats", cnt, 4);
    chk("bp.idle", o_idle, 1);

    // wrap: 258 lines with responses one cycle after issue
    do_reset();
    o_cmd_r = 1; o_wr_r = 1; o_rsp_r = 1;
    issued = 0; written = 0; pend = 0; pend_line = 0; nxt_line = 0;
    for (int c = 0; c < 700 && written < 258; c++) begin
      i_req_v = (issued < 258);
      i_rsp_v = pend; i_rsp_tag = 3'(pend_line); i_rsp_data = dat(pend_line);
      @(negedge clk);
      nxt_pend = 0;
      if (o_cmd_v && i_req_r) begin
        chk("wrap.tag", o_cmd_tag, issued % 8);
        chk("wrap.addr", o_cmd_addr, BASE + 64'((issued % 256) * 128));
        nxt_pend = 1; nxt_line = issued;
        issued++;
      end
      if (o_wr_v) begin
        chk("wrap.ptr", o_wr_ptr, written % 256);
        chk("wrap.data", o_wr_data, dat(written));
        written++;
      end
      adv();
      pend = nxt_pend; pend_line = nxt_line;
    end
    i_req_v = 0; i_rsp_v = 0;
    chk("wrap.issued", issued, 258);
    chk("wrap.written", written, 258);

    // functional reset with two lines outstanding
    do_reset();
    i_req_v = 1; o_cmd_r = 1; o_wr_r = 1; o_rsp_r = 0;
    repeat (2) adv();
    i_rst_v = 1;
    i_rsp_v = 1; i_rsp_tag = 0; i_rsp_data = dat(300);
    @(negedge clk);
    chk("frst.c0_rst_r", i_rst_r, 0);
    chk("frst.c0_req_r", i_req_r, 0);
    chk("frst.c0_cmd_v", o_cmd_v, 0);
    adv();
    i_rsp_tag = 1; i_rsp_data = dat(301);
    @(negedge clk);
    chk("frst.c1_wr_v", o_wr_v, 1);
    chk("frst.c1_ptr", o_wr_ptr, 0);
    chk("frst.c1_rst_r", i_rst_r, 0);
    chk("frst.c1_req_r", i_req_r, 0);
    adv();
    i_rsp_v = 0;
    @(negedge clk);
    chk("frst.c2_ptr", o_wr_ptr, 1);
    chk("frst.c2_data", o_wr_data, dat(301));
    chk("frst.c2_rst_r", i_rst_r, 0);
    adv();
    o_rsp_r = 1;
    @(negedge clk);
    chk("frst.c3_wr_v", o_wr_v, 0);
    chk("frst.c3_rsp_v", o_rsp_v, 1);
    chk("frst.c3_rst_r", i_rst_r, 0);
    chk("frst.c3_req_r", i_req_r, 0);
    adv();
    @(negedge clk);
    chk("frst.c4_rsp_v", o_rsp_v, 1);
    chk("frst.c4_rst_r", i_rst_r, 0);
    adv();
    @(negedge clk);
    chk("frst.c5_idle", o_idle, 1);
    chk("frst.c5_rst_r", i_rst_r, 1);
    chk("frst.c5_req_r", i_req_r, 0);
    adv();
    i_rst_v = 0;
    @(negedge clk);
    chk("frst.c6_cmd_v", o_cmd_v, 1);
    chk("frst.c6_tag", o_cmd_tag, 0);
    chk("frst.c6_addr", o_cmd_addr, BASE);
    adv();
    i_req_v = 0;
    i_rsp_v = 1; i_rsp_tag = 0; i_rsp_data = dat(310);
    adv();
    i_rsp_v = 0;
    @(negedge clk);
    chk("frst.c8_wr_v", o_wr_v, 1);
    chk("frst.c8_ptr", o_wr_ptr, 0);
    chk("frst.c8_data", o_wr_data, dat(310));
    adv();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
